mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one BITS-wide 4:1 multiplexed bus among four requesters.

---
 rtl/mux4_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one BITS-wide 4:1 bus among four requesters.
// It registers a one-hot grant and a bus select, and it forwards the granted source's data to a registered output.
module mux4_rr_arbiter #(
  parameter int BITS     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [3:0]      req_i,
  input  logic [BITS-1:0] d0_i,
  input  logic [BITS-1:0] d1_i,
  input  logic [BITS-1:0] d2_i,
  input  logic [BITS-1:0] d3_i,
  output logic [3:0]      grant_o,
  output logic [1:0]      sel_o,
  output logic [BITS-1:0] data_out_o,
  output logic            data_valid_o,
  output logic            busy_o
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ATIVO = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        sel_q, sel_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              busy_q, busy_d;
  logic [BITS-1:0]   data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  logic [BITS-1:0]   src [4];
  logic [3:0]        req_rot;
  logic [3:0]        owner_oh;
  logic [3:0]        winner_oh;
  logic [1:0]        offset;
  logic [1:0]        winner;
  logic              any_req;
  logic              others_pending;
  logic              at_limit;
  logic              release_grant;

  assign src[0] = d0_i;
  assign src[1] = d1_i;
  assign src[2] = d2_i;
  assign src[3] = d3_i;

  // req_rot[k] is the request at position ptr+k. The lowest set bit of req_rot is the round-robin winner.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign req_rot[gi]   = req_i[ptr_q + 2'(gi)];
    assign owner_oh[gi]  = (sel_q == 2'(gi));
    assign winner_oh[gi] = (winner == 2'(gi));
  end

  always_comb begin
    offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req_rot[k]) offset = 2'(k);
    end
  end

  assign winner         = ptr_q + offset;
  assign any_req        = |req_i;
  assign others_pending = |(req_i & ~owner_oh);
  assign at_limit       = (hold_cnt_q == HOLD_LAST);
  assign release_grant  = !req_i[sel_q] || (at_limit && others_pending);

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)       state_d = ATIVO;
      ATIVO:   if (release_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d    = winner_oh;
          sel_d      = winner;
          hold_cnt_d = '0;
          busy_d     = 1'b1;
        end else begin
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      ATIVO: begin
        if (release_grant) begin
          grant_d = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          busy_d  = 1'b0;
        end else if (!at_limit) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // The data path samples the registered grant, so data lags the grant by one cycle.
  always_comb begin
    data_valid_d = (state_q == ATIVO) && (grant_q != 4'b0000);
    data_out_d   = data_valid_d ? src[sel_q] : data_out_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ptr_q        <= 2'd0;
      grant_q      <= 4'b0000;
      sel_q        <= 2'd0;
      hold_cnt_q   <= '0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      hold_cnt_q   <= hold_cnt_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign grant_o      = grant_q;
  assign sel_o        = sel_q;
  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;

  a_grant_onehot0 : assert property (@(posedge clock_i) disable iff (reset_i) $onehot0(grant_q));
  a_busy_state    : assert property (@(posedge clock_i) disable iff (reset_i) busy_q == (state_q == ATIVO));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter with BITS=4 and MAX_HOLD=8.
// It samples the outputs 1 time unit after each rising clock edge and compares them with hand-computed values.
module tb_mux4_rr_arbiter;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic [3:0] req_i;
  logic [3:0] d0_i, d1_i, d2_i, d3_i;
  logic [3:0] grant_o;
  logic [1:0] sel_o;
  logic [3:0] data_out_o;
  logic       data_valid_o;
  logic       busy_o;

  int n_vec = 0;
  int n_err = 0;

  mux4_rr_arbiter #(.BITS(4), .MAX_HOLD(8)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .d0_i         (d0_i),
    .d1_i         (d1_i),
    .d2_i         (d2_i),
    .d3_i         (d3_i),
    .grant_o      (grant_o),
    .sel_o        (sel_o),
    .data_out_o   (data_out_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  logic [3:0] exp_data [4];
  logic [3:0] oh;

  initial begin
    d0_i = 4'h1; d1_i = 4'h5; d2_i = 4'hA; d3_i = 4'hC;
    exp_data[0] = 4'h1; exp_data[1] = 4'h5; exp_data[2] = 4'hA; exp_data[3] = 4'hC;
    reset_i = 1'b1;
    req_i   = 4'b1111;

    // Test 1: hold reset for two cycles while all four sources request.
    tick(); tick();
    check("rst_grant", grant_o, 4'b0000);
    check("rst_sel", sel_o, 2'd0);
    check("rst_data", data_out_o, 4'h0);
    check("rst_valid", data_valid_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);

    // Test 2: source 2 is the only requester.
    reset_i = 1'b0;
    req_i   = 4'b0100;
    tick();
    check("single_grant", grant_o, 4'b0100);
    check("single_sel", sel_o, 2'd2);
    check("single_busy", busy_o, 1'b1);
    check("single_valid0", data_valid_o, 1'b0);
    tick();
    check("single_data", data_out_o, 4'hA);
    check("single_valid1", data_valid_o, 1'b1);
    req_i = 4'b0000;
    tick();
    check("rel_grant", grant_o, 4'b0000);
    check("rel_busy", busy_o, 1'b0);
    tick();
    check("idle_valid", data_valid_o, 1'b0);
    check("idle_sel_kept", sel_o, 2'd2);
    check("idle_data_kept", data_out_o, 4'hA);

    // Test 4: the pointer is now 3, so the scan wraps from 3 to 0.
    req_i = 4'b0011;
    tick();
    check("wrap_grant", grant_o, 4'b0001);
    check("wrap_sel", sel_o, 2'd0);
    req_i = 4'b0000;
    tick(); tick();

    // Test 3: reset to return the pointer to 0, then rotate with all four requests held high.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    req_i   = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      oh = 4'b0001 << (s % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        check($sformatf("rot%0d_c%0d_grant", s, c), grant_o, oh);
        if (c == 1) begin
          check($sformatf("rot%0d_data", s), data_out_o, exp_data[s % 4]);
          check($sformatf("rot%0d_valid", s), data_valid_o, 1'b1);
        end
      end
      tick();
      check($sformatf("rot%0d_gap", s), grant_o, 4'b0000);
    end

    // Test 5: a sole requester never times out. The pointer is now 1.
    req_i = 4'b0010;
    tick();
    check("sole_first", grant_o, 4'b0010);
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("sole_c%0d", c), grant_o, 4'b0010);
    end
    // A competitor appears while the hold count is saturated, so the grant is released on the next edge.
    req_i = 4'b1010;
    tick();
    check("timeout_rel", grant_o, 4'b0000);
    tick();
    check("timeout_next", grant_o, 4'b1000);
    check("timeout_sel", sel_o, 2'd3);

    // Test 6: assert reset while source 3 holds the grant.
    reset_i = 1'b1;
    tick();
    check("midrst_grant", grant_o, 4'b0000);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_sel", sel_o, 2'd0);
    check("midrst_valid", data_valid_o, 1'b0);
    check("midrst_data", data_out_o, 4'h0);
    reset_i = 1'b0;
    req_i   = 4'b1001;
    tick();
    check("post_rst_grant", grant_o, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
